qcw_phase_nco: RTL

Parametrised phase-shift NCO for the QCW full-bridge, successor to the fixed-width single-output NCO. It generates four dead-time-protected gate-drive signals, two per bridge leg, with a runtime-programmable period and leg-B phase. New period and phase values are double-buffered and applied only at a period boundary. It sits in the `pwm_clk` domain between the control FSM and the GDT output pins, and provides graceful stop, immediate halt and a cycle counter for burst sequencing.

---
 rtl/qcw_phase_nco.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/qcw_phase_nco.sv
// Phase-shift NCO for the QCW full bridge: four dead-time protected gate drives
// with double-buffered period/phase, graceful stop, sticky halt and cycle counter.
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | gates off, count held at 0; waits for enable with no halt pending
// RUN   | count cycles 0..P-1, gates driven, shadow copied at each wrap
// STOP  | finishing the current period after enable fell; IDLE at the wrap
module qcw_phase_nco #(
    parameter int unsigned WIDTH      = 16,
    parameter int unsigned PERIOD_MIN = 'h100,
    parameter int unsigned PERIOD_MAX = 'h2000,
    parameter int unsigned DEADTIME   = 8
) (
    input  logic             pwm_clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             halt,
    input  logic             load,
    input  logic [WIDTH-1:0] period_next,
    input  logic [WIDTH-1:0] phase_next,
    output logic             leg_a_hi,
    output logic             leg_a_lo,
    output logic             leg_b_hi,
    output logic             leg_b_lo,
    output logic             next,
    output logic             running,
    output logic             halted,
    output logic [WIDTH-1:0] cycle_count
);

    localparam int unsigned DTW = (DEADTIME < 2) ? 1 : $clog2(DEADTIME + 1);
    localparam logic [DTW-1:0]   DT     = DTW'(DEADTIME);
    localparam logic [DTW-1:0]   DT_ONE = DTW'(1);
    localparam logic [WIDTH-1:0] ONE    = WIDTH'(1);
    localparam logic [WIDTH-1:0] P_MIN  = WIDTH'(PERIOD_MIN);
    localparam logic [WIDTH-1:0] P_MAX  = WIDTH'(PERIOD_MAX);

    if (DEADTIME >= PERIOD_MIN / 2) begin : g_bad_deadtime
        $error("qcw_phase_nco: DEADTIME must be below PERIOD_MIN/2");
    end
    if (PERIOD_MIN > PERIOD_MAX) begin : g_bad_range
        $error("qcw_phase_nco: PERIOD_MIN exceeds PERIOD_MAX");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_STOP = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] period_act, phase_act;
    logic [WIDTH-1:0] shadow_period, shadow_phase;
    logic [WIDTH-1:0] p_new, f_new, half;
    logic [WIDTH:0]   b_count;
    logic             raw_a, raw_b, raw_a_q, raw_b_q;
    logic [DTW-1:0]   dt_a_q, dt_b_q, dt_a_cur, dt_b_cur;
    logic             gate_a, gate_b;
    logic             wrap, start, quiet;

    function automatic logic [WIDTH-1:0] clamp_period(input logic [WIDTH-1:0] p);
        logic [WIDTH-1:0] r;
        r = p;
        if (p < P_MIN) r = P_MIN;
        else if (p > P_MAX) r = P_MAX;
        return r;
    endfunction

    always_comb begin
        p_new = clamp_period(shadow_period);
        f_new = (shadow_phase > p_new - ONE) ? p_new - ONE : shadow_phase;
        half  = period_act >> 1;
        raw_a = count_q < half;
        // Leg-B count kept one bit wider so count+P-F cannot overflow.
        if (count_q >= phase_act) b_count = {1'b0, count_q} - {1'b0, phase_act};
        else b_count = {1'b0, count_q} + {1'b0, period_act} - {1'b0, phase_act};
        raw_b    = b_count < {1'b0, half};
        dt_a_cur = (raw_a != raw_a_q) ? DT : dt_a_q;
        dt_b_cur = (raw_b != raw_b_q) ? DT : dt_b_q;
        gate_a   = dt_a_cur != '0;
        gate_b   = dt_b_cur != '0;
        wrap     = (state_q != S_IDLE) && (count_q == period_act - ONE) && !halt;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (enable && !halted) state_d = S_RUN;
            S_RUN:  if (!enable) state_d = S_STOP;
            S_STOP: begin
                if (enable) state_d = S_RUN;
                else if (wrap) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (halt) state_d = S_IDLE;
    end

    assign start   = (state_q == S_IDLE) && (state_d == S_RUN);
    assign quiet   = (state_q == S_IDLE) || halt;
    assign running = state_q != S_IDLE;

    always_ff @(posedge pwm_clk) begin
        if (reset) state_q <= S_IDLE;
        else state_q <= state_d;
    end

    always_ff @(posedge pwm_clk) begin
        if (reset) begin
            count_q       <= '0;
            period_act    <= P_MAX;
            phase_act     <= '0;
            shadow_period <= P_MAX;
            shadow_phase  <= '0;
            cycle_count   <= '0;
            halted        <= 1'b0;
            raw_a_q       <= 1'b0;
            raw_b_q       <= 1'b0;
            dt_a_q        <= '0;
            dt_b_q        <= '0;
            leg_a_hi      <= 1'b0;
            leg_a_lo      <= 1'b0;
            leg_b_hi      <= 1'b0;
            leg_b_lo      <= 1'b0;
            next          <= 1'b0;
        end else begin
            if (load) begin
                shadow_period <= period_next;
                shadow_phase  <= phase_next;
            end

            if (halt) halted <= 1'b1;
            else if (state_q == S_IDLE && !enable) halted <= 1'b0;

            if (state_d == S_IDLE || start || wrap) count_q <= '0;
            else count_q <= count_q + ONE;

            // The wrap copies the shadow as it stood before any coincident load.
            if (start || wrap) begin
                period_act <= p_new;
                phase_act  <= f_new;
            end

            if (start) cycle_count <= '0;
            else if (wrap && cycle_count != '1) cycle_count <= cycle_count + ONE;

            if (start) begin
                dt_a_q <= DT;
                dt_b_q <= DT;
            end else if (quiet) begin
                dt_a_q <= '0;
                dt_b_q <= '0;
            end else begin
                dt_a_q <= gate_a ? dt_a_cur - DT_ONE : '0;
                dt_b_q <= gate_b ? dt_b_cur - DT_ONE : '0;
            end

            if (quiet) begin
                raw_a_q  <= 1'b0;
                raw_b_q  <= 1'b0;
                leg_a_hi <= 1'b0;
                leg_a_lo <= 1'b0;
                leg_b_hi <= 1'b0;
                leg_b_lo <= 1'b0;
                next     <= 1'b0;
            end else begin
                raw_a_q  <= raw_a;
                raw_b_q  <= raw_b;
                leg_a_hi <= raw_a && !gate_a;
                leg_a_lo <= !raw_a && !gate_a;
                leg_b_hi <= raw_b && !gate_b;
                leg_b_lo <= !raw_b && !gate_b;
                next     <= wrap;
            end
        end
    end

endmodule
